apu_bus_ctrl: RTL and testbench
===============================

# apu_bus_ctrl

Bus-cycle sequencer between the SNES core's CPU-side I/O port accesses ($2140–$2143) and the external SNES APU module on the GPIO header. It serialises single-byte read/write requests into timed APU bus cycles with setup, strobe and hold phases. It sequences the APU reset line, supports a core-requested soft reset, and generates the free-running APU clock. The board top handles tri-stating and pin scrambling. This block drives the already-separated Dout/DEn and samples Din.

## Interface
Parameters:
- CLK_HALF, 2: iCLK cycles per APU_CLK half-period (≥1).
- SETUP_CYC, 2: cycles address/data are stable before the strobe (≥1).
- STROBE_CYC, 8: cycles WEn/RDn are held low (≥1).
- HOLD_CYC, 2: cycles address/data are held after the strobe (≥1).
- RST_CYC, 1024: cycles APU_RSTn is held low (≥1).

Ports:
- iCLK in 1: system clock, 50 MHz.
- iRST_N in 1: reset, active-low, synchronous.
- req in 1: access request; level, sampled in IDLE only.
- we in 1: 1 = write, 0 = read; sampled with req.
- addr in 2: APU port number; sampled with req.
- wdata in 8: write byte; sampled with req.
- ack out 1: one-cycle completion pulse.
- rdata out 8: read byte; valid from the ack cycle until the next read's ack.
- soft_rst in 1: one-cycle pulse that requests an APU reset sequence.
- busy out 1: high in every state except IDLE.
- APU_RSTn out 1: APU reset, active-low.
- APU_CLK out 1: APU clock.
- APU_WEn out 1: write strobe, active-low.
- APU_RDn out 1: read strobe, active-low.
- APU_DEn out 1: data-out enable, active-low (0 = FPGA drives).
- APU_A out 2: port address.
- APU_Dout out 8: write data.
- APU_Din in 8: read data from the APU.

## Operation
- States: RST_HOLD, IDLE, SETUP, STROBE, HOLD, DONE. One down-counter, 11 bits minimum and sized to the largest parameter, reloaded on every state entry.
- RST_HOLD: APU_RSTn=0, strobes high, DEn=1. After RST_CYC cycles → IDLE, and APU_RSTn=1.
- IDLE:
  - A pending soft_rst takes priority → RST_HOLD.
  - Otherwise req=1 latches we/addr/wdata → SETUP.
- SETUP: APU_A and APU_Dout driven from the latch. DEn=0 if write, else 1. Strobes high. After SETUP_CYC cycles → STROBE.
- STROBE: APU_WEn=0 (write) or APU_RDn=0 (read). On the last STROBE cycle's edge, APU_Din is registered into rdata (reads only). After STROBE_CYC cycles → HOLD.
- HOLD: strobes high, A/Dout/DEn unchanged. After HOLD_CYC cycles → DONE.
- DONE: one cycle, ack=1, DEn=1 → IDLE. req is ignored in DONE. The requester must drop req in the ack cycle or a new access starts in IDLE.
- soft_rst pulse arriving outside IDLE is latched into a pending flag. It is serviced after the current access's DONE, and the pending flag is cleared on entering RST_HOLD.
- APU_CLK is free-running: it toggles every CLK_HALF cycles, independent of the FSM. It keeps running during RST_HOLD.
- Writes never update rdata.

## Timing
- Reset values (iRST_N=0 at an edge): state RST_HOLD, counter=RST_CYC, APU_RSTn=0, APU_WEn=1, APU_RDn=1, APU_DEn=1, APU_A=0, APU_Dout=0, APU_CLK=0, ack=0, rdata=0, busy=1, pending soft_rst=0.
- Reset taking effect mid-access aborts the access with no ack. The next cycle shows reset values, and a full RST_CYC sequence follows.
- All outputs are registered.
- Access latency, from req sampled in IDLE at edge 0 to ack high: 1+SETUP_CYC+STROBE_CYC+HOLD_CYC cycles. The default is 13.
- Minimum access spacing is that latency plus 1 (the DONE cycle), because the next req is sampled in IDLE.
- WEn/RDn low-pulse width equals exactly STROBE_CYC cycles. The two strobes are never low simultaneously.
- DEn=0 is a strict superset of WEn=0, by at least SETUP_CYC cycles before and HOLD_CYC cycles after.

## Structure
- Shared package `snes_apu_pkg`: state enum, default cycle constants, port address constants (PORT0..PORT3).
- No sub-modules; the APU_CLK divider is an inline counter.

## Test plan
- Write at defaults (addr=2, wdata=0xA5): APU_A=2, Dout=0xA5, DEn=0 in cycles 1–12, WEn=0 in cycles 3–10, ack in cycle 13, RDn stays 1.
- Read (addr=1, APU_Din=0x3C during STROBE, then 0xFF after): RDn=0 in cycles 3–10, DEn stays 1, ack in cycle 13 with rdata=0x3C, which persists.
- Back-to-back with req held high: the second access's SETUP starts 14 cycles after the first, and each ack is exactly one cycle wide.
- iRST_N=0 in the 5th STROBE cycle: no ack, WEn=1 next cycle, APU_RSTn=0 for RST_CYC cycles, then busy=0.
- soft_rst pulsed during SETUP: the access completes with ack, then APU_RSTn=0 for RST_CYC cycles starting in the cycle after DONE, and req is ignored until IDLE.
- CLK_HALF=3: APU_CLK period is 6 cycles with a 50% duty cycle, and is uninterrupted across accesses and soft reset.

Source files
------------

// File: rtl/snes_apu_pkg.sv
// Shared definitions for the SNES APU bus sequencer: FSM states, default
// phase lengths, APU port numbers and a small sizing helper.
package snes_apu_pkg;

    typedef enum logic [2:0] {
        ST_RST_HOLD,
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_DONE
    } apu_state_t;

    typedef logic [1:0] apu_port_t;

    localparam int DEF_CLK_HALF   = 2;
    localparam int DEF_SETUP_CYC  = 2;
    localparam int DEF_STROBE_CYC = 8;
    localparam int DEF_HOLD_CYC   = 2;
    localparam int DEF_RST_CYC    = 1024;

    // CPU-visible ports $2140..$2143 map onto APU port numbers 0..3.
    localparam apu_port_t PORT0 = 2'd0;
    localparam apu_port_t PORT1 = 2'd1;
    localparam apu_port_t PORT2 = 2'd2;
    localparam apu_port_t PORT3 = 2'd3;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/apu_bus_ctrl_if.sv
// Core-side request/response bundle of the APU bus sequencer.
// master = the SNES core I/O logic, slave = the sequencer.
interface apu_bus_ctrl_if;
    import snes_apu_pkg::*;

    logic       req;
    logic       we;
    apu_port_t  addr;
    logic [7:0] wdata;
    logic       soft_rst;
    logic       ack;
    logic [7:0] rdata;
    logic       busy;

    modport master (
        output req, we, addr, wdata, soft_rst,
        input  ack, rdata, busy
    );

    modport slave (
        input  req, we, addr, wdata, soft_rst,
        output ack, rdata, busy
    );
endinterface

// File: rtl/apu_bus_ctrl.sv
// Serialises single-byte core accesses into timed APU bus cycles
// (setup / strobe / hold), sequences APU_RSTn after reset or a soft-reset
// request, and divides the system clock down to the free-running APU_CLK.
// Every output comes straight from a register.
module apu_bus_ctrl
    import snes_apu_pkg::*;
#(
    parameter int CLK_HALF   = DEF_CLK_HALF,
    parameter int SETUP_CYC  = DEF_SETUP_CYC,
    parameter int STROBE_CYC = DEF_STROBE_CYC,
    parameter int HOLD_CYC   = DEF_HOLD_CYC,
    parameter int RST_CYC    = DEF_RST_CYC
) (
    input  logic          iCLK,
    input  logic          iRST_N,
    apu_bus_ctrl_if.slave bus,
    output logic          APU_RSTn,
    output logic          APU_CLK,
    output logic          APU_WEn,
    output logic          APU_RDn,
    output logic          APU_DEn,
    output logic [1:0]    APU_A,
    output logic [7:0]    APU_Dout,
    input  logic [7:0]    APU_Din
);

    localparam int MAX_CYC = max_int(max_int(SETUP_CYC, STROBE_CYC),
                                     max_int(HOLD_CYC, RST_CYC));
    localparam int CNT_W   = max_int(11, $clog2(MAX_CYC + 1));
    localparam int DIV_W   = (CLK_HALF > 1) ? $clog2(CLK_HALF) : 1;

    apu_state_t       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             cnt_last;
    logic             pend_reg, pend_next;
    logic             we_reg, we_next;
    apu_port_t        addr_reg, addr_next;
    logic [7:0]       wdata_reg, wdata_next;
    logic [7:0]       rdata_reg, rdata_next;

    logic             ack_reg, ack_next;
    logic             busy_reg, busy_next;
    logic             rstn_reg, rstn_next;
    logic             wen_reg, wen_next;
    logic             rdn_reg, rdn_next;
    logic             den_reg, den_next;
    logic             drive_phase;

    logic [DIV_W-1:0] div_reg;
    logic             apu_clk_reg;

    // Length of each timed phase; the counter is reloaded with this on entry.
    function automatic logic [CNT_W-1:0] phase_len(input apu_state_t s);
        logic [CNT_W-1:0] len;
        case (s)
            ST_RST_HOLD: len = CNT_W'(RST_CYC);
            ST_SETUP:    len = CNT_W'(SETUP_CYC);
            ST_STROBE:   len = CNT_W'(STROBE_CYC);
            ST_HOLD:     len = CNT_W'(HOLD_CYC);
            default:     len = CNT_W'(1);
        endcase
        return len;
    endfunction

    assign cnt_last = (cnt_reg == CNT_W'(1));

    // Next-state logic, request latching, read capture and pending soft reset.
    always_comb begin
        state_next = state_reg;
        pend_next  = pend_reg | bus.soft_rst;
        we_next    = we_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        rdata_next = rdata_reg;

        case (state_reg)
            ST_RST_HOLD: begin
                if (cnt_last) state_next = ST_IDLE;
            end
            ST_IDLE: begin
                if (pend_reg || bus.soft_rst) begin
                    state_next = ST_RST_HOLD;
                end else if (bus.req) begin
                    state_next = ST_SETUP;
                    we_next    = bus.we;
                    addr_next  = bus.addr;
                    wdata_next = bus.wdata;
                end
            end
            ST_SETUP: begin
                if (cnt_last) state_next = ST_STROBE;
            end
            ST_STROBE: begin
                if (cnt_last) begin
                    state_next = ST_HOLD;
                    if (!we_reg) rdata_next = APU_Din;
                end
            end
            ST_HOLD: begin
                if (cnt_last) state_next = ST_DONE;
            end
            ST_DONE: begin
                // A soft reset raised during the access runs right after DONE.
                state_next = (pend_reg || bus.soft_rst) ? ST_RST_HOLD : ST_IDLE;
            end
            default: begin
                state_next = ST_RST_HOLD;
            end
        endcase

        if ((state_next == ST_RST_HOLD) && (state_reg != ST_RST_HOLD))
            pend_next = 1'b0;

        if (state_next != state_reg)
            cnt_next = phase_len(state_next);
        else if (state_reg == ST_IDLE)
            cnt_next = cnt_reg;
        else
            cnt_next = cnt_reg - CNT_W'(1);
    end

    // Pin levels for the coming cycle, decoded from the next state so they
    // can be registered without adding a cycle of latency.
    always_comb begin
        drive_phase = (state_next == ST_SETUP) || (state_next == ST_STROBE) ||
                      (state_next == ST_HOLD);
        rstn_next   = (state_next != ST_RST_HOLD);
        wen_next    = !((state_next == ST_STROBE) && we_next);
        rdn_next    = !((state_next == ST_STROBE) && !we_next);
        den_next    = !(drive_phase && we_next);
        ack_next    = (state_next == ST_DONE);
        busy_next   = (state_next != ST_IDLE);
    end

    // State, counter, latched request and registered outputs.
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            state_reg <= ST_RST_HOLD;
            cnt_reg   <= CNT_W'(RST_CYC);
            pend_reg  <= 1'b0;
            we_reg    <= 1'b0;
            addr_reg  <= PORT0;
            wdata_reg <= 8'h00;
            rdata_reg <= 8'h00;
            ack_reg   <= 1'b0;
            busy_reg  <= 1'b1;
            rstn_reg  <= 1'b0;
            wen_reg   <= 1'b1;
            rdn_reg   <= 1'b1;
            den_reg   <= 1'b1;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            pend_reg  <= pend_next;
            we_reg    <= we_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            rdata_reg <= rdata_next;
            ack_reg   <= ack_next;
            busy_reg  <= busy_next;
            rstn_reg  <= rstn_next;
            wen_reg   <= wen_next;
            rdn_reg   <= rdn_next;
            den_reg   <= den_next;
        end
    end

    // Free-running APU clock divider; only a hard reset restarts it.
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            div_reg     <= '0;
            apu_clk_reg <= 1'b0;
        end else if (div_reg == DIV_W'(CLK_HALF - 1)) begin
            div_reg     <= '0;
            apu_clk_reg <= ~apu_clk_reg;
        end else begin
            div_reg     <= div_reg + DIV_W'(1);
        end
    end

    assign bus.ack   = ack_reg;
    assign bus.rdata = rdata_reg;
    assign bus.busy  = busy_reg;
    assign APU_RSTn  = rstn_reg;
    assign APU_CLK   = apu_clk_reg;
    assign APU_WEn   = wen_reg;
    assign APU_RDn   = rdn_reg;
    assign APU_DEn   = den_reg;
    assign APU_A     = addr_reg;
    assign APU_Dout  = wdata_reg;

endmodule

// File: tb/tb_apu_bus_ctrl.sv
// Bench for apu_bus_ctrl: a timeline model (reset window and access window
// expressed as edge offsets) checked against the DUT every cycle, plus
// directed scenarios with hand-computed cycle numbers.
module tb_apu_bus_ctrl;
    import snes_apu_pkg::*;

    localparam int S  = 2;
    localparam int T  = 8;
    localparam int H  = 2;
    localparam int RC = 1024;
    localparam int CH = 3;
    localparam int L  = 1 + S + T + H;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       APU_RSTn, APU_CLK, APU_WEn, APU_RDn, APU_DEn;
    logic [1:0] APU_A;
    logic [7:0] APU_Dout, APU_Din;

    int checks = 0;
    int errors = 0;

    apu_bus_ctrl_if bus ();

    apu_bus_ctrl #(
        .CLK_HALF  (CH),
        .SETUP_CYC (S),
        .STROBE_CYC(T),
        .HOLD_CYC  (H),
        .RST_CYC   (RC)
    ) dut (
        .iCLK    (clk),
        .iRST_N  (rst_n),
        .bus     (bus.slave),
        .APU_RSTn(APU_RSTn),
        .APU_CLK (APU_CLK),
        .APU_WEn (APU_WEn),
        .APU_RDn (APU_RDn),
        .APU_DEn (APU_DEn),
        .APU_A   (APU_A),
        .APU_Dout(APU_Dout),
        .APU_Din (APU_Din)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- timeline model ----------------
    int         e_cnt = 0;
    bit         model_ok = 0;
    int         rst_start = 0;
    int         clk_ref = 0;
    bit         acc_on = 0;
    int         acc_start = 0;
    bit         m_we = 0;
    logic [1:0] m_addr = 0;
    logic [7:0] m_wdata = 0;
    logic [7:0] m_rdata = 0;
    bit         m_pend = 0;

    function automatic bit in_rst(input int e);
        return (e - rst_start) < RC;
    endfunction

    function automatic bit in_acc(input int e);
        return acc_on && (e - acc_start) >= 0 && (e - acc_start) < L;
    endfunction

    task automatic model_step();
        bit prev_idle, prev_done;
        e_cnt++;
        if (!rst_n) begin
            rst_start = e_cnt; clk_ref = e_cnt; acc_on = 0; m_pend = 0;
            m_addr = 0; m_wdata = 0; m_rdata = 0; model_ok = 1;
        end else if (model_ok) begin
            prev_idle = !in_rst(e_cnt - 1) && !in_acc(e_cnt - 1);
            prev_done = in_acc(e_cnt - 1) && (e_cnt - 1 - acc_start) == L - 1;
            if (acc_on && !m_we && (e_cnt - acc_start) == S + T) m_rdata = APU_Din;
            if (prev_idle) begin
                if (bus.soft_rst || m_pend) begin
                    rst_start = e_cnt; m_pend = 0;
                end else if (bus.req) begin
                    acc_on = 1; acc_start = e_cnt; m_we = bus.we;
                    m_addr = bus.addr; m_wdata = bus.wdata;
                end
            end else if (prev_done && (bus.soft_rst || m_pend)) begin
                rst_start = e_cnt; m_pend = 0;
            end else if (bus.soft_rst) begin
                m_pend = 1;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Compare every output against the model, once per cycle.
    initial forever begin
        int  off;
        bit  ir, ia;
        @(negedge clk);
        if (model_ok) begin
            ir  = in_rst(e_cnt);
            ia  = in_acc(e_cnt);
            off = e_cnt - acc_start;
            chk("m_rstn",  APU_RSTn, !ir);
            chk("m_busy",  bus.busy, ir || ia);
            chk("m_ack",   bus.ack,  ia && off == L - 1);
            chk("m_den",   APU_DEn,  !(ia && m_we && off < L - 1));
            chk("m_wen",   APU_WEn,  !(ia && m_we && off >= S && off < S + T));
            chk("m_rdn",   APU_RDn,  !(ia && !m_we && off >= S && off < S + T));
            chk("m_addr",  APU_A,    m_addr);
            chk("m_dout",  APU_Dout, m_wdata);
            chk("m_rdata", bus.rdata, m_rdata);
            chk("m_clk",   APU_CLK,  ((e_cnt - clk_ref) / CH) % 2);
        end
    end

    // APU_CLK period/duty monitor, enabled around the soft-reset scenario.
    bit clk_meas = 0;
    initial begin
        int  last_rise, last_fall, ticks;
        bit  prev;
        last_rise = -1; last_fall = -1; ticks = 0; prev = 0;
        forever begin
            @(negedge clk);
            ticks++;
            if (!clk_meas) begin
                last_rise = -1; last_fall = -1;
            end else begin
                if (APU_CLK && !prev) begin
                    if (last_rise >= 0) chk("clk_period", ticks - last_rise, 6);
                    last_rise = ticks;
                end
                if (!APU_CLK && prev && last_rise >= 0) begin
                    chk("clk_high", ticks - last_rise, 3);
                    last_fall = ticks;
                end
            end
            prev = APU_CLK;
        end
    end

    task automatic wait_idle(input int bound, output int n);
        n = 0;
        while (bus.busy !== 1'b0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", n < bound, 1);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int wf, wl, df, dl, ak, ak2, nlow, nack, consec, n, rf, b0, fall2;
        int falls[4];
        int nf;
        bit pden, pack;

        rst_n = 0; bus.req = 0; bus.we = 0; bus.addr = PORT0; bus.wdata = 0;
        bus.soft_rst = 0; APU_Din = 8'hFF;
        repeat (3) @(negedge clk);
        chk("rst_rstn", APU_RSTn, 0);  chk("rst_busy", bus.busy, 1);
        chk("rst_wen", APU_WEn, 1);    chk("rst_rdn", APU_RDn, 1);
        chk("rst_den", APU_DEn, 1);    chk("rst_a", APU_A, 0);
        chk("rst_dout", APU_Dout, 0);  chk("rst_ack", bus.ack, 0);
        chk("rst_rdata", bus.rdata, 0); chk("rst_clk", APU_CLK, 0);
        rst_n = 1;
        wait_idle(1100, n);
        $display("txn reset_release idle_after=%0d", n);

        // Write addr=2 wdata=A5
        bus.we = 1; bus.addr = PORT2; bus.wdata = 8'hA5; bus.req = 1;
        wf = -1; wl = -1; df = -1; dl = -1; ak = -1; nlow = 0;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            if (c == 1) bus.req = 0;
            if (APU_WEn === 1'b0) begin if (wf < 0) wf = c; wl = c; end
            if (APU_DEn === 1'b0) begin if (df < 0) df = c; dl = c; end
            if (APU_RDn !== 1'b1) nlow++;
            if (bus.ack === 1'b1) ak = c;
            if (c == 5) begin chk("wr_a", APU_A, 2); chk("wr_dout", APU_Dout, 8'hA5); end
        end
        chk("wr_wen_first", wf, 3);  chk("wr_wen_last", wl, 10);
        chk("wr_den_first", df, 1);  chk("wr_den_last", dl, 12);
        chk("wr_ack_cycle", ak, 13); chk("wr_rdn_low", nlow, 0);
        $display("txn write addr=2 wdata=a5 ack_cycle=%0d", ak);

        // Read addr=1, APU drives 3C during the strobe
        bus.we = 0; bus.addr = PORT1; bus.req = 1;
        wf = -1; wl = -1; ak = -1; nlow = 0;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            if (c == 1) bus.req = 0;
            if (APU_RDn === 1'b0) begin if (wf < 0) wf = c; wl = c; end
            if (APU_DEn !== 1'b1) nlow++;
            if (bus.ack === 1'b1) begin ak = c; chk("rd_rdata_ack", bus.rdata, 8'h3C); end
            if (c == 15) chk("rd_rdata_hold", bus.rdata, 8'h3C);
            APU_Din = (c >= 3 && c <= 10) ? 8'h3C : 8'hFF;
        end
        chk("rd_rdn_first", wf, 3); chk("rd_rdn_last", wl, 10);
        chk("rd_den_low", nlow, 0); chk("rd_ack_cycle", ak, 13);
        $display("txn read addr=1 rdata=%02h ack_cycle=%0d", bus.rdata, ak);

        // Back-to-back writes with req held high
        bus.we = 1; bus.addr = PORT0; bus.wdata = 8'h11; bus.req = 1;
        nf = 0; nack = 0; consec = 0; ak = -1; ak2 = -1; pden = 1; pack = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (c == 5) bus.wdata = 8'h22;
            if (c == 15) bus.req = 0;
            if (pden && APU_DEn === 1'b0 && nf < 4) begin falls[nf] = c; nf++; end
            if (bus.ack === 1'b1) begin
                nack++;
                if (pack) consec++;
                if (ak < 0) ak = c; else ak2 = c;
            end
            if (c == 20) chk("b2b_dout2", APU_Dout, 8'h22);
            pden = APU_DEn; pack = bus.ack;
        end
        chk("b2b_setups", nf, 2);
        if (nf == 2) chk("b2b_spacing", falls[1] - falls[0], 14);
        chk("b2b_acks", nack, 2); chk("b2b_ack_width", consec, 0);
        chk("b2b_ack1", ak, 13);  chk("b2b_ack2", ak2, 27);
        $display("txn back_to_back acks=%0d at %0d,%0d", nack, ak, ak2);

        // Hard reset in the 5th strobe cycle
        bus.we = 1; bus.addr = PORT3; bus.wdata = 8'h77; bus.req = 1;
        nack = 0;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (c == 1) bus.req = 0;
            if (bus.ack === 1'b1) nack++;
        end
        rst_n = 0;
        @(negedge clk);
        chk("hr_wen", APU_WEn, 1); chk("hr_rstn", APU_RSTn, 0);
        rst_n = 1;
        nlow = 1;
        while (APU_RSTn === 1'b0 && nlow < 2000) begin
            @(negedge clk);
            if (bus.ack === 1'b1) nack++;
            if (APU_RSTn === 1'b0) nlow++;
        end
        chk("hr_rstn_len", nlow, RC); chk("hr_no_ack", nack, 0);
        chk("hr_busy_after", bus.busy, 0);
        $display("txn hard_reset rstn_low=%0d", nlow);

        // Soft reset during SETUP, req held high throughout
        clk_meas = 1;
        bus.we = 1; bus.addr = PORT2; bus.wdata = 8'h5A; bus.req = 1;
        ak = -1; rf = -1; nlow = 0; b0 = -1; fall2 = -1; pden = 1;
        for (int c = 1; c <= 1055; c++) begin
            @(negedge clk);
            if (c == 1) bus.soft_rst = 1;
            if (c == 2) bus.soft_rst = 0;
            if (c == 1039) bus.req = 0;
            if (bus.ack === 1'b1 && ak < 0) ak = c;
            if (APU_RSTn === 1'b0) begin if (rf < 0) rf = c; nlow++; end
            if (c > 14 && bus.busy === 1'b0 && b0 < 0) b0 = c;
            if (c > 14 && pden && APU_DEn === 1'b0 && fall2 < 0) fall2 = c;
            pden = APU_DEn;
        end
        clk_meas = 0;
        chk("sr_ack_cycle", ak, 13);   chk("sr_rst_first", rf, 14);
        chk("sr_rst_len", nlow, RC);   chk("sr_idle_cycle", b0, 1038);
        chk("sr_next_setup", fall2, 1039);
        $display("txn soft_reset ack=%0d rst_from=%0d len=%0d", ak, rf, nlow);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
